demo_regbank: RTL and testbench



---
 rtl/demo_regbank_pkg.sv | 33 +++
 rtl/demo_led_gen.sv | 62 ++++++
 rtl/demo_regbank.sv | 176 +++++++++++++++++
 tb/tb_demo_regbank.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demo_regbank_pkg.sv
// demo_regbank shared definitions: register indices, CTRL fields,
// LED mode encoding and status field layout.
package demo_regbank_pkg;

  localparam int REG_CTRL     = 0;
  localparam int REG_LED      = 1;
  localparam int REG_BLINK    = 2;
  localparam int REG_PWM      = 3;
  localparam int REG_COUNTER  = 4;
  localparam int REG_ID       = 5;
  localparam int REG_STATUS   = 6;
  localparam int REG_RSVD     = 7;
  localparam int REG_SCRATCH0 = 8;

  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_MODE_MSB = 1;
  localparam int CTRL_CNT_EN   = 8;
  localparam int CTRL_CNT_CLR  = 9;

  localparam int STAT_BAD      = 0;
  localparam int STAT_WCNT_LSB = 16;
  localparam int WCNT_W        = 16;

  localparam int PWM_W = 8;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_PWM    = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

endpackage

// File: rtl/demo_led_gen.sv
// demo_led_gen: LED output stage with static, blink, pwm and off modes.
// Ports: i_clk, i_reset (sync, active-high), i_mode, i_led_val,
//   i_blink_div (half-period, 0 acts as 1), i_duty, i_restart
//   (clears blink phase/counter), o_led (registered drive).
module demo_led_gen
  import demo_regbank_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LED_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  mode_e             i_mode,
  input  logic [LED_W-1:0]  i_led_val,
  input  logic [DATA_W-1:0] i_blink_div,
  input  logic [PWM_W-1:0]  i_duty,
  input  logic              i_restart,
  output logic [LED_W-1:0]  o_led
);

  logic [DATA_W-1:0] r_bcnt;
  logic              r_phase;
  logic [PWM_W-1:0]  r_pwm;
  logic [DATA_W-1:0] w_last;
  logic [LED_W-1:0]  w_led;

  // Terminal count; a divider of 0 behaves like 1.
  assign w_last = (i_blink_div == '0) ? '0
                : i_blink_div - DATA_W'(1);

  always_comb begin
    w_led = '0;
    case (i_mode)
      MODE_STATIC: w_led = i_led_val;
      MODE_BLINK:  w_led = r_phase ? i_led_val : '0;
      MODE_PWM:    w_led = (r_pwm < i_duty) ? i_led_val : '0;
      default:     w_led = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
      r_pwm   <= '0;
      o_led   <= '0;
    end else begin
      r_pwm <= r_pwm + PWM_W'(1);
      o_led <= w_led;
      if (i_restart) begin
        r_bcnt  <= '0;
        r_phase <= 1'b0;
      end else if (r_bcnt >= w_last) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + DATA_W'(1);
      end
    end
  end

endmodule

// File: rtl/demo_regbank.sv
// demo_regbank: register bank with counter, ID, status, scratch and LEDs.
// Ports: S_AXI_ACLK, i_reset (sync, active-high), write strobe i_we with
//   i_waddr/i_wdata/i_wstrb, read strobe i_rd with i_raddr, o_rdata
//   (registered, one cycle after i_rd, holds otherwise), o_led.
module demo_regbank
  import demo_regbank_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 32,
  parameter int          NSCRATCH  = 8,
  parameter int          LED_W     = 4,
  parameter int          BLINK_RST = 25000000,
  parameter logic [31:0] ID_VAL    = 32'hDE30_0002
) (
  input  logic                S_AXI_ACLK,
  input  logic                i_reset,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_waddr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic                i_rd,
  input  logic [ADDR_W-1:0]   i_raddr,
  output logic [DATA_W-1:0]   o_rdata,
  output logic [LED_W-1:0]    o_led
);

  localparam int SW   = DATA_W / 8;
  localparam int IW   = ADDR_W - 2;
  localparam int LAST = REG_SCRATCH0 + NSCRATCH - 1;
  localparam int NS_A = (NSCRATCH > 0) ? NSCRATCH : 1;

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [SW-1:0]     strb
  );
    logic [DATA_W-1:0] m;
    m = old_v;
    for (int b = 0; b < SW; b++)
      if (strb[b]) m[8*b +: 8] = new_v[8*b +: 8];
    return m;
  endfunction

  mode_e               r_mode;
  logic                r_cnt_en;
  logic [LED_W-1:0]    r_led;
  logic [DATA_W-1:0]   r_blink;
  logic [PWM_W-1:0]    r_duty;
  logic [DATA_W-1:0]   r_counter;
  logic                r_bad;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [DATA_W-1:0]   r_scr [NS_A];
  logic [DATA_W-1:0]   r_rdata;

  logic [IW-1:0]       w_widx;
  logic [IW-1:0]       w_ridx;
  logic                w_wr;
  logic                w_bad;
  logic                w_sel_ctrl;
  logic                w_sel_led;
  logic                w_sel_blink;
  logic                w_sel_pwm;
  logic                w_sel_stat;
  logic                w_clr;
  logic                w_w1c;
  logic                w_restart;
  logic [DATA_W-1:0]   w_ctrl_rd;
  logic [DATA_W-1:0]   w_ctrl_new;
  logic [DATA_W-1:0]   w_led_new;
  logic [DATA_W-1:0]   w_pwm_new;
  logic [DATA_W-1:0]   w_rval;
  logic                w_unused;

  assign w_widx = i_waddr[ADDR_W-1:2];
  assign w_ridx = i_raddr[ADDR_W-1:2];

  assign w_wr  = i_we & (w_widx <= IW'(LAST));
  assign w_bad = (i_we & (w_widx > IW'(LAST)))
               | (i_rd & (w_ridx > IW'(LAST)));

  assign w_sel_ctrl  = w_wr & (w_widx == IW'(REG_CTRL));
  assign w_sel_led   = w_wr & (w_widx == IW'(REG_LED));
  assign w_sel_blink = w_wr & (w_widx == IW'(REG_BLINK));
  assign w_sel_pwm   = w_wr & (w_widx == IW'(REG_PWM));
  assign w_sel_stat  = w_wr & (w_widx == IW'(REG_STATUS));

  always_comb begin
    w_ctrl_rd = '0;
    w_ctrl_rd[CTRL_MODE_MSB:CTRL_MODE_LSB] = r_mode;
    w_ctrl_rd[CTRL_CNT_EN] = r_cnt_en;
  end

  // CNT_CLR reads back 0, so merging against the readback
  // leaves it set only when the write carries it.
  assign w_ctrl_new = merge(w_ctrl_rd, i_wdata, i_wstrb);
  assign w_led_new  = merge(DATA_W'(r_led), i_wdata, i_wstrb);
  assign w_pwm_new  = merge(DATA_W'(r_duty), i_wdata, i_wstrb);

  assign w_clr     = w_sel_ctrl & w_ctrl_new[CTRL_CNT_CLR];
  assign w_w1c     = w_sel_stat & i_wstrb[0] & i_wdata[STAT_BAD];
  assign w_restart = w_sel_ctrl | w_sel_blink;

  always_comb begin
    w_rval = '0;
    if (w_ridx == IW'(REG_CTRL)) begin
      w_rval = w_ctrl_rd;
    end else if (w_ridx == IW'(REG_LED)) begin
      w_rval = DATA_W'(r_led);
    end else if (w_ridx == IW'(REG_BLINK)) begin
      w_rval = r_blink;
    end else if (w_ridx == IW'(REG_PWM)) begin
      w_rval = DATA_W'(r_duty);
    end else if (w_ridx == IW'(REG_COUNTER)) begin
      w_rval = r_counter;
    end else if (w_ridx == IW'(REG_ID)) begin
      w_rval = DATA_W'(ID_VAL);
    end else if (w_ridx == IW'(REG_STATUS)) begin
      w_rval[STAT_BAD] = r_bad;
      w_rval[STAT_WCNT_LSB +: WCNT_W] = r_wcnt;
    end
    for (int i = 0; i < NSCRATCH; i++)
      if (w_ridx == IW'(REG_SCRATCH0 + i)) w_rval = r_scr[i];
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (i_reset) begin
      r_mode    <= MODE_STATIC;
      r_cnt_en  <= 1'b0;
      r_led     <= '0;
      r_blink   <= DATA_W'(BLINK_RST);
      r_duty    <= PWM_W'(8'h80);
      r_counter <= '0;
      r_bad     <= 1'b0;
      r_wcnt    <= '0;
      r_rdata   <= '0;
      for (int i = 0; i < NS_A; i++) r_scr[i] <= '0;
    end else begin
      if (w_sel_ctrl) begin
        r_mode   <= mode_e'(w_ctrl_new[CTRL_MODE_MSB:CTRL_MODE_LSB]);
        r_cnt_en <= w_ctrl_new[CTRL_CNT_EN];
      end
      if (w_sel_led)   r_led   <= w_led_new[LED_W-1:0];
      if (w_sel_blink) r_blink <= merge(r_blink, i_wdata, i_wstrb);
      if (w_sel_pwm)   r_duty  <= w_pwm_new[PWM_W-1:0];
      for (int i = 0; i < NSCRATCH; i++)
        if (w_wr && w_widx == IW'(REG_SCRATCH0 + i))
          r_scr[i] <= merge(r_scr[i], i_wdata, i_wstrb);
      if (w_clr)         r_counter <= '0;
      else if (r_cnt_en) r_counter <= r_counter + DATA_W'(1);
      // A new bad access wins over a same-cycle clear.
      r_bad <= w_bad | (r_bad & ~w_w1c);
      if (w_wr) r_wcnt <= r_wcnt + WCNT_W'(1);
      if (i_rd) r_rdata <= w_rval;
    end
  end

  assign o_rdata = r_rdata;

  demo_led_gen #(
    .DATA_W (DATA_W),
    .LED_W  (LED_W)
  ) u_led (
    .i_clk       (S_AXI_ACLK),
    .i_reset     (i_reset),
    .i_mode      (r_mode),
    .i_led_val   (r_led),
    .i_blink_div (r_blink),
    .i_duty      (r_duty),
    .i_restart   (w_restart),
    .o_led       (o_led)
  );

  assign w_unused = ^{i_waddr[1:0], i_raddr[1:0], w_ctrl_new,
                      w_led_new, w_pwm_new};

endmodule

// File: tb/tb_demo_regbank.sv
// Self-checking bench for demo_regbank: directed steps plus randomized
// register traffic compared against a behavioural register-map model.
module tb_demo_regbank;

  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam int          NS   = 8;
  localparam int          LW   = 4;
  localparam int          BRST = 25000000;
  localparam logic [31:0] IDV  = 32'hDE30_0002;

  logic          clk = 1'b0;
  logic          reset;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          rd;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic [LW-1:0] led;

  always #5 clk = ~clk;

  demo_regbank #(
    .DATA_W(DW), .ADDR_W(AW), .NSCRATCH(NS), .LED_W(LW),
    .BLINK_RST(BRST), .ID_VAL(IDV)
  ) dut (
    .S_AXI_ACLK(clk), .i_reset(reset),
    .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .i_wstrb(wstrb),
    .i_rd(rd), .i_raddr(raddr), .o_rdata(rdata), .o_led(led)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0]  m_mode;
  logic        m_en;
  logic [3:0]  m_led;
  logic [31:0] m_blink;
  logic [7:0]  m_duty;
  logic        m_bad;
  logic [15:0] m_wcnt;
  logic [31:0] m_scr [NS];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_mode = 0; m_en = 0; m_led = 0; m_blink = BRST; m_duty = 8'h80;
    m_bad = 0; m_wcnt = 0;
    for (int i = 0; i < NS; i++) m_scr[i] = 0;
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] o,
    input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(input int idx);
    case (idx)
      0: return {23'b0, m_en, 6'b0, m_mode};
      1: return {28'b0, m_led};
      2: return m_blink;
      3: return {24'b0, m_duty};
      5: return IDV;
      6: return {m_wcnt, 15'b0, m_bad};
      default: if (idx >= 8 && idx < 8 + NS) return m_scr[idx-8];
    endcase
    return 0;
  endfunction

  task automatic mwrite(input int idx, input logic [31:0] d,
                        input logic [3:0] s);
    logic [31:0] t;
    if (idx >= 8 + NS) return;
    m_wcnt++;
    t = lanes(mread(idx), d, s);
    case (idx)
      0: begin m_mode = t[1:0]; m_en = t[8]; end
      1: m_led = t[3:0];
      2: m_blink = t;
      3: m_duty = t[7:0];
      default: if (idx >= 8) m_scr[idx-8] = t;
    endcase
  endtask

  task automatic step(input logic we_, input logic [31:0] wa,
    input logic [31:0] wd, input logic [3:0] ws, input logic rd_,
    input logic [31:0] ra, output logic [31:0] exp_rd);
    int  wi, ri;
    bit  badn, clr;
    wi = int'(wa[31:2]);
    ri = int'(ra[31:2]);
    exp_rd = mread(ri);
    badn = (we_ && wi >= 8 + NS) || (rd_ && ri >= 8 + NS);
    clr  = we_ && wi == 6 && ws[0] && wd[0];
    we = we_; waddr = wa; wdata = wd; wstrb = ws;
    rd = rd_; raddr = ra;
    @(posedge clk); #1;
    we = 0; rd = 0;
    if (we_) mwrite(wi, wd, ws);
    m_bad = badn | (m_bad & !clr);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] e;
    step(1, a, d, s, 0, 0, e);
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a);
    logic [31:0] e;
    step(0, 0, 0, 0, 1, a, e);
    chk(tag, rdata, e);
  endtask

  initial begin
    logic [31:0] e;
    int on, other;
    reset = 1; we = 0; rd = 0;
    waddr = 0; wdata = 0; wstrb = 0; raddr = 0;
    mreset();
    repeat (3) @(posedge clk);
    #1 reset = 0;

    chk("rst_rdata", rdata, 0);
    chk("rst_led", {28'b0, led}, 0);
    rdchk("rst_ctrl", 32'h0);
    chk("rst_blink_c", mread(2), BRST);
    rdchk("rst_blink", 32'h8);
    rdchk("rst_pwm", 32'hC);
    chk("rst_pwm_c", rdata, 32'h80);
    rdchk("rst_id", 32'h14);
    chk("rst_id_c", rdata, IDV);

    wr(32'h20, 32'hFFFF_FFFF, 4'b1111);
    wr(32'h20, 32'h1234_5678, 4'b0101);
    rdchk("strb", 32'h20);
    chk("strb_c", rdata, 32'hFF34_FF78);

    step(1, 32'h24, 32'hCAFE_0001, 4'hF, 1, 32'h24, e);
    chk("rw_same_old", rdata, 0);
    rdchk("rw_same_new", 32'h24);

    wr(32'h0, 32'h301, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      rdchk("cnt_ctrlchk", 32'h0);
      chk("cnt_run_sel", rdata, 32'h101);
      rdchk("cnt_dummy", 32'h14);
      step(0, 0, 0, 0, 1, 32'h10, e);
      chk("cnt_run", rdata, 32'(3 * i + 2));
    end
    wr(32'h0, 32'h0, 4'b0011);
    step(0, 0, 0, 0, 1, 32'h10, e);
    chk("cnt_freeze", rdata, 32'd13);
    step(0, 0, 0, 0, 1, 32'h10, e);
    chk("cnt_freeze2", rdata, 32'd13);

    wr(32'h8, 32'd3, 4'hF);
    wr(32'h4, 32'hA, 4'hF);
    wr(32'h0, 32'h1, 4'b0001);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk("blink", {28'b0, led}, (((k - 1) / 3) % 2) ? 32'hA : 32'h0);
    end
    rdchk("ctrl_blink", 32'h0);

    wr(32'hC, 32'd64, 4'hF);
    wr(32'h0, 32'h2, 4'b0001);
    repeat (2) @(posedge clk);
    #1 on = 0; other = 0;
    for (int k = 0; k < 256; k++) begin
      if (led == 4'hA) on++; else if (led != 0) other++;
      @(posedge clk); #1;
    end
    chk("pwm64_on", on, 64);
    chk("pwm64_other", other, 0);
    wr(32'hC, 32'd0, 4'hF);
    repeat (2) @(posedge clk);
    #1 on = 0;
    for (int k = 0; k < 256; k++) begin
      if (led != 0) on++;
      @(posedge clk); #1;
    end
    chk("pwm0_on", on, 0);

    rdchk("bad_rd", 32'h100);
    chk("bad_rd_c", rdata, 0);
    rdchk("bad_stat", 32'h18);
    chk("bad_stat_c", {31'b0, rdata[0]}, 1);
    step(1, 32'h18, 32'h1, 4'h1, 1, 32'h200, e);
    chk("bad_setwins_rd", rdata, 0);
    rdchk("bad_setwins", 32'h18);
    chk("bad_setwins_c", {31'b0, rdata[0]}, 1);
    wr(32'h18, 32'h1, 4'h1);
    rdchk("bad_clr", 32'h18);
    chk("bad_clr_c", {31'b0, rdata[0]}, 0);
    wr(32'h40, 32'h1234, 4'hF);
    wr(32'h1C, 32'h5555, 4'hF);
    rdchk("rsvd", 32'h1C);
    rdchk("wcnt", 32'h18);

    for (int n = 0; n < 300; n++) begin
      logic        w, r;
      int          wi, ri;
      logic [31:0] wa, ra, d;
      logic [3:0]  s;
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      wi = $urandom_range(1, 20);
      ri = $urandom_range(0, 20);
      if (ri == 4) ri = 5;
      wa = 32'(wi * 4 + $urandom_range(0, 3));
      ra = 32'(ri * 4 + $urandom_range(0, 3));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      step(w, wa, d, s, r, ra, e);
      if (r) chk("rand", rdata, e);
    end
    rdchk("rand_stat", 32'h18);

    we = 1; waddr = 32'h20; wdata = 32'h77; wstrb = 4'hF;
    rd = 1; raddr = 32'h14; reset = 1;
    @(posedge clk); #1;
    we = 0; rd = 0; reset = 0;
    mreset();
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_led", {28'b0, led}, 0);
    rdchk("mid_rst_scr", 32'h20);
    rdchk("mid_rst_stat", 32'h18);
    rdchk("mid_rst_blink", 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
